axis_stream_checker: RTL
========================

Name: axis_stream_checker

Overview:
- Synthesizable AXI-Stream sink for the data offload bench; the receiving counterpart of the auto-increment source sequencer.
- Sits on the offload destination (DAC-side) stream. Generates tready to a programmable pattern and checks every accepted byte against the expected auto-increment sequence.
- Tracks cyclic replay wrap and reports beat, TLAST and error counts plus a first-mismatch capture, for oneshot and cyclic offload modes.

Parameters:
- DATA_WIDTH, 64: tdata width in bits; a multiple of 8, from 8 to 1024.
- CNT_WIDTH, 32: width of the beat, TLAST and error counters.
- TIME_WIDTH, 16: width of the ready high/low time fields.

Ports:
- clk  in  1  single clock domain.
- resetn  in  1  asynchronous active-low reset.
- enable  in  1  level signal. 1 = run; a falling edge freezes tready low and holds all status.
- clear  in  1  single-cycle pulse. Zeroes counters and the capture, and reloads the expected byte from cfg_seed.
- cfg_ready_mode  in  2  0 = always ready, 1 = pulsed high/low, 2 = never ready, 3 = reserved (treated as 0).
- cfg_high_time  in  TIME_WIDTH  ready-high cycles in mode 1.
- cfg_low_time  in  TIME_WIDTH  ready-low cycles in mode 1.
- cfg_seed  in  8  first expected byte value.
- cfg_wrap_beats  in  CNT_WIDTH  beats per replay buffer. 0 = never wrap.
- cfg_wrap_on_last  in  1  1 = also restart the expected pattern after a TLAST beat.
- s_axis_valid  in  1  stream valid.
- s_axis_ready  out  1  stream ready.
- s_axis_data  in  DATA_WIDTH  stream data; byte 0 is in the LSBs.
- s_axis_last  in  1  stream last.
- beat_count  out  CNT_WIDTH  accepted beats; saturates.
- last_count  out  CNT_WIDTH  accepted TLAST beats; saturates.
- error_count  out  CNT_WIDTH  beats with at least one byte mismatch; saturates.
- error  out  1  sticky; set by any mismatch.
- err_beat  out  CNT_WIDTH  beat_count value of the first failing beat.
- err_data  out  DATA_WIDTH  received data of the first failing beat.
- err_expected  out  DATA_WIDTH  expected data of the first failing beat.

Behaviour:
- Reset values: s_axis_ready=0. All counters, error, err_beat, err_data and err_expected are 0. Internal expected byte = 0; it is loaded from cfg_seed on the first cycle enable is high after reset or after clear.
- Acceptance: a beat is accepted when s_axis_valid && s_axis_ready on a rising clk. s_axis_ready never depends combinationally on s_axis_valid.
- Ready FSM, states IDLE, HIGH, LOW, STALL:
  - IDLE while enable=0; ready=0.
  - On enable=1: mode 0 goes to HIGH and stays there. Mode 1 goes to HIGH. Mode 2 goes to STALL.
  - Mode 1: HIGH holds for cfg_high_time cycles, then LOW holds for cfg_low_time cycles, then back to HIGH.
  - Mode 1 with high_time=0 is treated as 1. low_time=0 means ready stays high continuously.
  - ready=1 only in HIGH. ready is registered, so the first ready comes 1 cycle after enable rises.
  - enable=0 in any state returns to IDLE the next cycle.
- Expected data: byte k of an accepted beat is (E + k) mod 256, where E is the expected byte at the start of that beat. After the beat, E advances by DATA_WIDTH/8 mod 256.
- Check pipeline, 1 stage:
  - Cycle 0: register the accepted data and the expected vector.
  - Cycle 1: compare. On mismatch, increment error_count and set error.
  - If error was 0 before this mismatch, capture err_beat, err_data and err_expected.
  - Net latency: status outputs change 1 cycle after acceptance for beat_count and last_count, and 2 cycles after for the error outputs.
- Wrap: track beats within the current buffer.
  - When the accepted beat is number cfg_wrap_beats (cfg_wrap_beats != 0), or cfg_wrap_on_last=1 and s_axis_last=1, E reloads to cfg_seed and the in-buffer count returns to 0.
  - If both conditions hit on the same beat, a single reload happens.
- beat_count increments every accepted beat. Unlike the in-buffer count, it does not wrap.
- Saturation: every counter holds at all-ones.
- clear has priority over a same-cycle acceptance: that beat is not counted and not checked. The FSM state is unaffected.
- Config is sampled live. Changing it while running takes effect on the next FSM state entry or the next beat.
- Asynchronous reset mid-transfer drops ready immediately and discards the in-flight compare.

Decomposition:
- Package axis_stream_checker_pkg holds: the ready_mode_t enum (READY_ALWAYS, READY_PULSED, READY_NEVER) and the FSM state enum.
- Sub-module axis_ready_gen: the ready FSM with its high/low counter. Inputs: enable, mode, cfg_high_time, cfg_low_time. Output: ready.

Test Plan:
- Mode 0, DATA_WIDTH=64, seed=0x00, 4 beats of bytes 0x00..0x1F -> beat_count=4, error=0, ready high from 1 cycle after enable.
- Mode 1, high=3, low=2, valid held high -> ready pattern 1,1,1,0,0 repeating; 6 beats accepted in 10 cycles.
- Byte 5 of beat 2 corrupted to 0xFF -> error_count=1, err_beat=2, err_expected byte 5=0x15, err_data byte 5=0xFF; a second corruption on beat 3 leaves the capture unchanged.
- cfg_wrap_beats=4, seed=0x10, cyclic replay of a 4-beat buffer sent 3 times -> beat_count=12, error=0. Same traffic with wrap_beats=0 -> error_count=8.
- cfg_wrap_on_last=1, TLAST on beat 2 coinciding with wrap_beats=3 on the following buffer -> last_count increments and each TLAST/wrap gives a single reload, error=0.
- clear asserted while valid&&ready, and async reset mid-burst -> that beat is not counted; after reset ready=0, counters 0, and the pattern restarts at seed.

Source files
------------

// File: rtl/axis_stream_checker_pkg.sv
// Shared types for the AXI-Stream sink checker: ready-pattern modes and ready FSM states.
package axis_stream_checker_pkg;

   typedef enum logic [1:0] {
      READY_ALWAYS = 2'd0,
      READY_PULSED = 2'd1,
      READY_NEVER  = 2'd2
   } ready_mode_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HIGH  = 2'd1,
      ST_LOW   = 2'd2,
      ST_STALL = 2'd3
   } ready_state_t;

endpackage

// File: rtl/axis_ready_gen.sv
// tready pattern generator: always / pulsed high-low / never, registered output.
module axis_ready_gen
   import axis_stream_checker_pkg::*;
#(
   parameter int unsigned TIME_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  enable,
   input  logic [1:0]            mode,
   input  logic [TIME_WIDTH-1:0] cfg_high_time,
   input  logic [TIME_WIDTH-1:0] cfg_low_time,
   output logic                  ready
);

   ready_state_t          state, state_next;
   logic [TIME_WIDTH-1:0] cnt, cnt_next;
   logic [TIME_WIDTH-1:0] high_end;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // A zero high time behaves as one cycle.
   assign high_end = (cfg_high_time == '0) ? '0 : cfg_high_time - TIME_WIDTH'(1);

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      if (!enable) begin
         state_next = ST_IDLE;
         cnt_next   = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               cnt_next   = '0;
               state_next = (ready_mode_t'(mode) == READY_NEVER) ? ST_STALL : ST_HIGH;
            end
            ST_HIGH: begin
               if (ready_mode_t'(mode) == READY_PULSED && cfg_low_time != '0) begin
                  if (cnt >= high_end) begin
                     state_next = ST_LOW;
                     cnt_next   = '0;
                  end else begin
                     cnt_next = cnt + TIME_WIDTH'(1);
                  end
               end
            end
            ST_LOW: begin
               if (cfg_low_time == '0 || cnt >= cfg_low_time - TIME_WIDTH'(1)) begin
                  state_next = ST_HIGH;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt + TIME_WIDTH'(1);
               end
            end
            ST_STALL: state_next = ST_STALL;
            default:  state_next = ST_IDLE;
         endcase
      end
   end

   assign ready = (state == ST_HIGH);

endmodule

// File: rtl/axis_stream_checker.sv
// AXI-Stream sink: programmable tready, auto-increment byte pattern check with
// replay wrap, saturating status counters and first-mismatch capture.
module axis_stream_checker
   import axis_stream_checker_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned CNT_WIDTH  = 32,
   parameter int unsigned TIME_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  enable,
   input  logic                  clear,
   input  logic [1:0]            cfg_ready_mode,
   input  logic [TIME_WIDTH-1:0] cfg_high_time,
   input  logic [TIME_WIDTH-1:0] cfg_low_time,
   input  logic [7:0]            cfg_seed,
   input  logic [CNT_WIDTH-1:0]  cfg_wrap_beats,
   input  logic                  cfg_wrap_on_last,
   input  logic                  s_axis_valid,
   output logic                  s_axis_ready,
   input  logic [DATA_WIDTH-1:0] s_axis_data,
   input  logic                  s_axis_last,
   output logic [CNT_WIDTH-1:0]  beat_count,
   output logic [CNT_WIDTH-1:0]  last_count,
   output logic [CNT_WIDTH-1:0]  error_count,
   output logic                  error,
   output logic [CNT_WIDTH-1:0]  err_beat,
   output logic [DATA_WIDTH-1:0] err_data,
   output logic [DATA_WIDTH-1:0] err_expected
);

   localparam int unsigned NBYTES    = DATA_WIDTH / 8;
   localparam logic [7:0]  BYTE_STEP = 8'(NBYTES % 256);

   logic                  accept, reload, seed_pending;
   logic [7:0]            exp_byte, e_cur;
   logic [DATA_WIDTH-1:0] exp_vec, p_data, p_exp;
   logic [CNT_WIDTH-1:0]  buf_cnt, p_beat;
   logic                  p_valid;

   axis_ready_gen #(.TIME_WIDTH(TIME_WIDTH)) u_ready_gen (
      .clk           (clk),
      .resetn        (resetn),
      .enable        (enable),
      .mode          (cfg_ready_mode),
      .cfg_high_time (cfg_high_time),
      .cfg_low_time  (cfg_low_time),
      .ready         (s_axis_ready)
   );

   assign accept = s_axis_valid && s_axis_ready;
   // Seed is used directly while a reload is pending so a beat on the load cycle still sees it.
   assign e_cur  = seed_pending ? cfg_seed : exp_byte;
   assign reload = ((cfg_wrap_beats != '0) && (buf_cnt == cfg_wrap_beats - CNT_WIDTH'(1)))
                 || (cfg_wrap_on_last && s_axis_last);

   always_comb begin
      exp_vec = '0;
      for (int unsigned k = 0; k < NBYTES; k++) begin
         exp_vec[8*k +: 8] = e_cur + 8'(k);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         seed_pending <= 1'b1;
         exp_byte     <= '0;
         buf_cnt      <= '0;
         p_valid      <= 1'b0;
         p_data       <= '0;
         p_exp        <= '0;
         p_beat       <= '0;
         beat_count   <= '0;
         last_count   <= '0;
         error_count  <= '0;
         error        <= 1'b0;
         err_beat     <= '0;
         err_data     <= '0;
         err_expected <= '0;
      end else if (clear) begin
         seed_pending <= 1'b1;
         buf_cnt      <= '0;
         p_valid      <= 1'b0;
         beat_count   <= '0;
         last_count   <= '0;
         error_count  <= '0;
         error        <= 1'b0;
         err_beat     <= '0;
         err_data     <= '0;
         err_expected <= '0;
      end else begin
         if (seed_pending && enable) begin
            exp_byte     <= cfg_seed;
            seed_pending <= 1'b0;
         end
         p_valid <= accept;
         if (accept) begin
            p_data       <= s_axis_data;
            p_exp        <= exp_vec;
            p_beat       <= beat_count;
            seed_pending <= 1'b0;
            if (beat_count != '1) beat_count <= beat_count + CNT_WIDTH'(1);
            if (s_axis_last && last_count != '1) last_count <= last_count + CNT_WIDTH'(1);
            if (reload) begin
               exp_byte <= cfg_seed;
               buf_cnt  <= '0;
            end else begin
               exp_byte <= e_cur + BYTE_STEP;
               if (buf_cnt != '1) buf_cnt <= buf_cnt + CNT_WIDTH'(1);
            end
         end
         if (p_valid && p_data != p_exp) begin
            error <= 1'b1;
            if (error_count != '1) error_count <= error_count + CNT_WIDTH'(1);
            if (!error) begin
               err_beat     <= p_beat;
               err_data     <= p_data;
               err_expected <= p_exp;
            end
         end
      end
   end

endmodule
